// File: rtl/iir_coef_loader.sv
// Streams a biquad coefficient set into a shadow bank and swaps it into the active bank on sample_en.
// Optional IIR_COEF_CHECKSUM_EN appends a modulo-2^COEF_W checksum word to every set.
module iir_coef_loader #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned COEF_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [COEF_W-1:0]                s_data,
  input  logic                             s_last,
  input  logic                             sample_en,
  output logic [NUM_STAGES*5*COEF_W-1:0]   coef_flat,
  output logic                             load_done,
  output logic                             load_err
);

  localparam int unsigned N = NUM_STAGES * 5;
`ifdef IIR_COEF_CHECKSUM_EN
  localparam int unsigned LEN = N + 1;
`else
  localparam int unsigned LEN = N;
`endif
  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPend} state_t;

  // Unity-gain pass-through: b0 = largest positive Q1.15 value, everything else zero.
  function automatic logic [N*COEF_W-1:0] pass_through();
    logic [N*COEF_W-1:0] v;
    v = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      v[(5*s)*COEF_W +: COEF_W] = {1'b0, {(COEF_W-1){1'b1}}};
    end
    return v;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [COEF_W-1:0]  shadow [N];
  logic [CNT_W-1:0]   idx;
  logic               beat;
  logic               is_final;
  logic               bad;
`ifdef IIR_COEF_CHECKSUM_EN
  logic [COEF_W-1:0]  sum;
  logic [COEF_W-1:0]  sum_nxt;
`endif

  always_comb begin
    idx      = (state == StIdle) ? '0 : cnt;
    beat     = s_valid && s_ready && (state != StPend);
    is_final = (idx == LAST_IDX);
    bad      = (s_last != is_final);
`ifdef IIR_COEF_CHECKSUM_EN
    sum_nxt = ((state == StIdle) ? '0 : sum) + s_data;
    if (is_final && (s_data != sum)) bad = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      s_ready   <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      coef_flat <= pass_through();
      for (int unsigned k = 0; k < N; k++) shadow[k] <= '0;
`ifdef IIR_COEF_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        StIdle, StLoad: begin
          s_ready <= 1'b1;
          if (beat) begin
            // Decoded write; the checksum index matches no shadow slot and is never stored.
            for (int unsigned k = 0; k < N; k++) begin
              if (idx == CNT_W'(k)) shadow[k] <= s_data;
            end
`ifdef IIR_COEF_CHECKSUM_EN
            sum <= sum_nxt;
`endif
            if (bad) begin
              load_err <= 1'b1;
              cnt      <= '0;
              state    <= StIdle;
            end else if (is_final) begin
              cnt     <= '0;
              s_ready <= 1'b0;
              state   <= StPend;
            end else begin
              cnt   <= idx + 1'b1;
              state <= StLoad;
            end
          end
        end
        StPend: begin
          s_ready <= 1'b0;
          if (sample_en) begin
            for (int unsigned k = 0; k < N; k++) coef_flat[k*COEF_W +: COEF_W] <= shadow[k];
            load_done <= 1'b1;
            s_ready   <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          s_ready <= 1'b1;
          cnt     <= '0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coef_loader.sv
// Scoreboard bench for iir_coef_loader: stimulus queues expected swap/error events, a monitor checks them.
module tb_iir_coef_loader;

  localparam int NS = 5;
  localparam int W  = 16;
  localparam int N  = NS * 5;
`ifdef IIR_COEF_CHECKSUM_EN
  localparam int LEN = N + 1;
`else
  localparam int LEN = N;
`endif

  typedef logic [N*W-1:0] vec_t;
  typedef struct {
    bit   is_err;
    vec_t coef;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         sample_en;
  vec_t         coef_flat;
  logic         load_done;
  logic         load_err;

  iir_coef_loader #(.NUM_STAGES(NS), .COEF_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .sample_en (sample_en),
    .coef_flat (coef_flat),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_active;
  vec_t pass_v;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t pack(input logic [W-1:0] w[$]);
    vec_t v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = w[k];
    return v;
  endfunction

  // Monitor: pops one expectation per pulse and tracks what the active bank must hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_active = pass_v;
      q.delete();
      check("coef_in_reset", coef_flat, pass_v);
      check("ready_in_reset", vec_t'(s_ready), vec_t'(0));
    end else begin
      check("done_err_exclusive", vec_t'(load_done & load_err), vec_t'(0));
      if (load_done || load_err) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got done=%b err=%b want no pulse", load_done, load_err);
        end else begin
          e_mon = q.pop_front();
          check("pulse_is_err", vec_t'(load_err), vec_t'(e_mon.is_err));
          if (!e_mon.is_err) exp_active = e_mon.coef;
        end
      end
      check("coef_flat", coef_flat, exp_active);
    end
  end

  // Sends one set. last_at: beat index carrying s_last (-1 = never). stop_after > 0 truncates
  // the set (for reset aborts) and queues no expectation.
  task automatic send_set(input logic [W-1:0] w[$], input int last_at, input logic [W-1:0] delta,
                          input int gap_pct, input bit se_noise, input int stop_after);
    logic [W-1:0] beats[$];
    logic [W-1:0] sum;
    int           nbeats;
    int           t;
    exp_t         e;
    beats = w;
    sum   = '0;
    foreach (w[k]) sum += w[k];
    if (LEN > N) beats.push_back(sum + delta);
    nbeats = (last_at >= 0) ? last_at + 1 : LEN;
    if (stop_after > 0) nbeats = stop_after;
    if (stop_after == 0) begin
      e.is_err = (last_at != LEN - 1) || (LEN > N && delta != 0);
      e.coef   = pack(w);
      q.push_back(e);
    end
    for (int i = 0; i < nbeats; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid   = 1'b0;
        sample_en = se_noise ? 1'($urandom_range(1)) : 1'b0;
        @(posedge clk); #1;
        sample_en = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = (i == last_at);
      t = 0;
      while (!s_ready) begin
        @(posedge clk); #1;
        t++;
        if (t > 50) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ready_timeout: got s_ready=0 for %0d cycles want 1", t);
          s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic swap(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      check("ready_low_in_pend", vec_t'(s_ready), vec_t'(0));
      @(posedge clk); #1;
    end
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_words(output logic [W-1:0] w[$]);
    w.delete();
    for (int k = 0; k < N; k++) w.push_back(W'($urandom));
  endtask

  logic [W-1:0] words[$];

  initial begin
    pass_v = '0;
    for (int s = 0; s < NS; s++) pass_v[(5*s)*W +: W] = 16'h7FFF;
    exp_active = pass_v;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_before_first_edge", vec_t'(s_ready), vec_t'(0));
    @(posedge clk); #1;
    check("ready_after_release", vec_t'(s_ready), vec_t'(1));
    check("reset_pass_through", coef_flat, pass_v);
    repeat (5) @(posedge clk);
    #1;

    // Ramp set 1..25 held in PEND for 10 cycles.
    words.delete();
    for (int k = 1; k <= N; k++) words.push_back(W'(k));
    send_set(words, LEN - 1, '0, 0, 1'b0, 0);
    swap(10);
    check("stage2_a1", vec_t'(coef_flat[13*W +: W]), vec_t'(16'h000E));
    check("ready_after_swap", vec_t'(s_ready), vec_t'(1));

    // Early s_last on word 12, then a good set.
    rand_words(words);
    send_set(words, 11, '0, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    rand_words(words);
    send_set(words, LEN - 1, '0, 0, 1'b0, 0);
    swap(3);

    // Missing s_last on the final word.
    rand_words(words);
    send_set(words, -1, '0, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Random gaps with sample_en noise during LOAD.
    for (int r = 0; r < 4; r++) begin
      rand_words(words);
      send_set(words, LEN - 1, '0, 50, 1'b1, 0);
      swap($urandom_range(5));
    end

    // Reset at word 17, then a clean reload.
    rand_words(words);
    send_set(words, -1, '0, 0, 1'b0, 17);
    rst = 1'b1;
    #1;
    check("coef_async_reset", coef_flat, pass_v);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rand_words(words);
    send_set(words, LEN - 1, '0, 20, 1'b1, 0);
    swap(2);

`ifdef IIR_COEF_CHECKSUM_EN
    words.delete();
    for (int k = 0; k < N; k++) words.push_back(16'h0100);
    send_set(words, LEN - 1, '0, 0, 1'b0, 0);
    swap(1);
    rand_words(words);
    send_set(words, LEN - 1, 16'h0001, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", vec_t'(q.size()), vec_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_coef_loader.md
IIR_COEF_LOADER -- requirements
Module: iir_coef_loader

Interface
REQ-001 Parameter NUM_STAGES, default 5: number of biquad stages fed.
REQ-002 Parameter COEF_W, default 16: coefficient width, signed Q1.15.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 s_valid  input  1: coefficient word valid.
REQ-006 s_ready  output  1: loader accepts word; a beat transfers when s_valid and s_ready are both high.
REQ-007 s_data  input  COEF_W: coefficient word, two's complement.
REQ-008 s_last  input  1: marks final word of a coefficient set.
REQ-009 sample_en  input  1: one-cycle strobe at the filter sample boundary; the only permitted swap instant.
REQ-010 coef_flat  output  NUM_STAGES*5*COEF_W: active bank; stage s slot j at bits [(5s+j)*COEF_W +: COEF_W], slot order b0,b1,b2,a1,a2.
REQ-011 load_done  output  1: one-cycle pulse when the active bank is updated.
REQ-012 load_err  output  1: one-cycle pulse when a set is rejected.

Function
REQ-013 Banks: shadow bank (written by stream) and active bank (drives coef_flat); coef_flat changes only on a swap or a reset.
REQ-014 FSM states IDLE, LOAD, PEND; s_ready = 1 in IDLE and LOAD, 0 in PEND.
REQ-015 IDLE: accepted beat writes shadow index 0, word counter := 1, next state LOAD.
REQ-016 LOAD: each accepted beat writes shadow[counter] and increments counter; index k maps to stage k/5, slot k%5.
REQ-017 Set length N = NUM_STAGES*5 words (25 by default); the final beat is index N-1.
REQ-018 s_last high on index N-1 -> PEND; s_last high on any earlier index, or low on index N-1 -> load_err pulse next cycle, shadow contents discarded, counter := 0, state IDLE, active bank unchanged.
REQ-019 PEND: on sample_en copy whole shadow to active in one cycle, pulse load_done in the same edge, state IDLE.
REQ-020 sample_en in IDLE or LOAD has no effect; s_valid in PEND is ignored and the word is not consumed.
REQ-021 A new set may begin the cycle after the swap; load_done and load_err never assert together.
REQ-022 No arithmetic on coefficients except the checksum in REQ-027; words are stored bit-exact.

Reset
REQ-023 On rst: state IDLE, counter 0, load_done 0, load_err 0, shadow bank all 0.
REQ-024 On rst: active bank = pass-through: every stage b0 = 0x7FFF, b1 = b2 = a1 = a2 = 0x0000.
REQ-025 Reset mid-load or in PEND aborts the set with no load_err pulse and restores REQ-024 values.
REQ-026 s_ready is 0 while rst is high and 1 from the first clock edge after release.

Configuration
REQ-027 Macro IIR_COEF_CHECKSUM_EN defined: set length N+1; word N is a checksum equal to the modulo-2^COEF_W sum of words 0..N-1; s_last expected on word N; mismatch -> load_err, IDLE, active unchanged; checksum word is never stored in the shadow bank.
REQ-028 Macro undefined: no checksum word, set length N, no summing logic synthesised.

Verification
REQ-029 Reset release, no stimulus -> coef_flat stage 0..4 b0 = 0x7FFF, all others 0; s_ready = 1; no pulses.
REQ-030 Stream 25 words 0x0001..0x0019, s_last on word 25, sample_en 10 cycles later -> s_ready low for those 10 cycles, coef_flat updates only on the sample_en edge, stage 2 a1 = 0x000E, single load_done pulse.
REQ-031 s_last on word 12 -> load_err pulse, coef_flat unchanged, next complete set loads normally.
REQ-032 Random s_valid gaps (~50%) during a 25-word load, sample_en pulses during LOAD -> no swap until PEND; final coef_flat matches stream order.
REQ-033 rst asserted at word 17 -> coef_flat returns to pass-through, no load_err, counter restarts at 0.
REQ-034 With IIR_COEF_CHECKSUM_EN: 25 words 0x0100 plus checksum 0x1900 -> swap; checksum 0x1901 -> load_err, no swap.
